// File: rtl/control_frame_buffer_write_only.sv
// Write-side frame-buffer controller: turns a captured pixel stream into registered RAM writes.
// Optional macro FB_WR_SKIP_FIRST_FRAME_EN suppresses writes for the first complete frame after reset.
module control_frame_buffer_write_only #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [15:0]           resolution_width_i,
    input  logic [15:0]           resolution_depth_i,
    input  logic                  frame_start_i,
    input  logic                  pixel_valid_i,
    input  logic [DATA_WIDTH-1:0] pixel_data_i,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] addr_wr_o,
    output logic [DATA_WIDTH-1:0] data_wr_o,
    output logic                  frame_done_o,
    output logic                  frame_err_o,
    output logic                  page_written_once_o
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_C = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_C  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_WAIT_SYNC = 1'b0,
        S_WRITE     = 1'b1
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH-1:0] total_r;

    logic [ADDR_WIDTH-1:0] width_ext_s;
    logic [ADDR_WIDTH-1:0] depth_ext_s;
    logic [ADDR_WIDTH-1:0] new_total_s;
    logic [ADDR_WIDTH-1:0] cur_total_s;
    logic [ADDR_WIDTH-1:0] cur_ptr_s;
    logic                  res_ok_s;
    logic                  start_ok_s;
    logic                  active_s;
    logic                  accept_s;
    logic                  last_s;
    logic                  skip_s;

    // Resolve frame start ahead of the pixel so a coincident pixel lands at address 0 of the new frame
    always_comb begin
        width_ext_s = ADDR_WIDTH'(resolution_width_i);
        depth_ext_s = ADDR_WIDTH'(resolution_depth_i);
        new_total_s = (width_ext_s * depth_ext_s) - ONE_C;
        res_ok_s    = (resolution_width_i != 16'd0) && (resolution_depth_i != 16'd0);
        start_ok_s  = frame_start_i && res_ok_s;
        if (start_ok_s) begin
            cur_total_s = new_total_s;
            cur_ptr_s   = ZERO_C;
        end else begin
            cur_total_s = total_r;
            cur_ptr_s   = ptr_r;
        end
        if (start_ok_s) begin
            active_s = 1'b1;
        end else if ((state_r == S_WRITE) && !frame_start_i) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        accept_s = pixel_valid_i && active_s;
        last_s   = accept_s && (cur_ptr_s == cur_total_s);
    end

`ifdef FB_WR_SKIP_FIRST_FRAME_EN
    logic skip_r;

    // Armed at reset; consumed only by a frame that actually completes
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            skip_r <= 1'b1;
        end else if (last_s) begin
            skip_r <= 1'b0;
        end else begin
            skip_r <= skip_r;
        end
    end

    assign skip_s = skip_r;
`else
    assign skip_s = 1'b0;
`endif

    // Frame FSM, pointer bookkeeping and registered RAM/status outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r             <= S_WAIT_SYNC;
            ptr_r               <= ZERO_C;
            total_r             <= ZERO_C;
            wr_o                <= 1'b0;
            addr_wr_o           <= ZERO_C;
            data_wr_o           <= {DATA_WIDTH{1'b0}};
            frame_done_o        <= 1'b0;
            frame_err_o         <= 1'b0;
            page_written_once_o <= 1'b0;
        end else begin
            wr_o         <= accept_s && !skip_s;
            frame_done_o <= last_s;
            frame_err_o  <= frame_start_i && (state_r == S_WRITE);

            if (accept_s && !skip_s) begin
                addr_wr_o <= cur_ptr_s;
                data_wr_o <= pixel_data_i;
            end

            if (last_s && !skip_s) begin
                page_written_once_o <= 1'b1;
            end

            if (start_ok_s) begin
                total_r <= new_total_s;
            end

            if (last_s) begin
                ptr_r <= ZERO_C;
            end else if (accept_s) begin
                ptr_r <= cur_ptr_s + ONE_C;
            end else if (frame_start_i) begin
                ptr_r <= ZERO_C;
            end

            case (state_r)
                S_WAIT_SYNC: begin
                    if (start_ok_s && !last_s) begin
                        state_r <= S_WRITE;
                    end else begin
                        state_r <= S_WAIT_SYNC;
                    end
                end
                S_WRITE: begin
                    // A restart with zero resolution cannot define a frame, so wait for a usable one
                    if (frame_start_i && !res_ok_s) begin
                        state_r <= S_WAIT_SYNC;
                    end else if (last_s) begin
                        state_r <= S_WAIT_SYNC;
                    end else begin
                        state_r <= S_WRITE;
                    end
                end
                default: begin
                    state_r <= S_WAIT_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_frame_buffer_write_only.sv
// Bench for control_frame_buffer_write_only: directed vector table, reset sequence, randomized model check.
module tb_control_frame_buffer_write_only;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] resolution_width_i;
    logic [15:0] resolution_depth_i;
    logic        frame_start_i;
    logic        pixel_valid_i;
    logic [15:0] pixel_data_i;
    logic        wr_o;
    logic [31:0] addr_wr_o;
    logic [15:0] data_wr_o;
    logic        frame_done_o;
    logic        frame_err_o;
    logic        page_written_once_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    control_frame_buffer_write_only #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .resolution_width_i  (resolution_width_i),
        .resolution_depth_i  (resolution_depth_i),
        .frame_start_i       (frame_start_i),
        .pixel_valid_i       (pixel_valid_i),
        .pixel_data_i        (pixel_data_i),
        .wr_o                (wr_o),
        .addr_wr_o           (addr_wr_o),
        .data_wr_o           (data_wr_o),
        .frame_done_o        (frame_done_o),
        .frame_err_o         (frame_err_o),
        .page_written_once_o (page_written_once_o)
    );

    typedef struct {
        logic        fs;
        logic        pv;
        logic [15:0] d;
        logic [15:0] w;
        logic [15:0] h;
        logic        ewr;
        logic [31:0] ea;
        logic [15:0] ed;
        logic        edone;
        logic        eerr;
        logic        epage;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] la;
    logic [15:0] ld;
    logic        pg;

    // Record one cycle; address/data expectations hold their last written value
    task automatic add(input logic fs, input logic pv, input logic [15:0] d, input logic [15:0] w,
                       input logic [15:0] h, input logic ewr, input int ea, input logic edone,
                       input logic eerr);
        vec_t v;
        if (ewr) begin
            la = 32'(ea);
            ld = d;
        end
        if (edone) pg = 1'b1;
        v.fs = fs; v.pv = pv; v.d = d; v.w = w; v.h = h;
        v.ewr = ewr; v.ea = la; v.ed = ld; v.edone = edone; v.eerr = eerr; v.epage = pg;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic fs, input logic pv, input logic [15:0] d, input logic [15:0] w,
                         input logic [15:0] h);
        frame_start_i      = fs;
        pixel_valid_i      = pv;
        pixel_data_i       = d;
        resolution_width_i = w;
        resolution_depth_i = h;
    endtask

    task automatic check(input string name, input logic ewr, input logic [31:0] ea, input logic [15:0] ed,
                         input logic edone, input logic eerr, input logic epage);
        n_checks++;
        if ({wr_o, addr_wr_o, data_wr_o, frame_done_o, frame_err_o, page_written_once_o} !==
            {ewr, ea, ed, edone, eerr, epage}) begin
            n_fail++;
            $display("FAIL %s: got wr=%b addr=%0d data=%h done=%b err=%b page=%b, want wr=%b addr=%0d data=%h done=%b err=%b page=%b",
                     name, wr_o, addr_wr_o, data_wr_o, frame_done_o, frame_err_o, page_written_once_o,
                     ewr, ea, ed, edone, eerr, epage);
        end
    endtask

    task automatic step(input logic fs, input logic pv, input logic [15:0] d, input logic [15:0] w,
                        input logic [15:0] h);
        drive(fs, pv, d, w, h);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'd4, 16'd2);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    // Reference: a frame is a queue of addresses still owed; each accepted pixel consumes one
    int          q[$];
    logic [31:0] m_addr;
    logic [15:0] m_data;
    logic        m_page;
    logic        m_skip;

    initial begin
        do_reset();
        check("reset_state", 1'b0, 32'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifndef FB_WR_SKIP_FIRST_FRAME_EN
        la = 32'd0; ld = 16'h0000; pg = 1'b0;
        // Basic frame 4x2
        add(1'b1, 1'b0, 16'h0000, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 16'(i + 1), 16'd4, 16'd2, 1'b1, i, i == 7, 1'b0);
        add(1'b0, 1'b0, 16'h0000, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        // Gapped pixels, then overflow pixels that must be dropped
        add(1'b1, 1'b0, 16'h0000, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 1'b1, 16'(16'h0011 + i), 16'd4, 16'd2, 1'b1, i, i == 7, 1'b0);
            add(1'b0, 1'b0, 16'h0000, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 16'h00EE, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        // Short frame: restart after 5 pixels
        add(1'b1, 1'b0, 16'h0000, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 16'(16'h0020 + i), 16'd4, 16'd2, 1'b1, i, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'h0000, 16'd4, 16'd2, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 16'(16'h0030 + i), 16'd4, 16'd2, 1'b1, i, i == 7, 1'b0);
        // Coincident start and pixel
        add(1'b1, 1'b1, 16'hABCD, 16'd4, 16'd2, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) add(1'b0, 1'b1, 16'(16'h0040 + i), 16'd4, 16'd2, 1'b1, i, i == 7, 1'b0);
        // Zero resolution starts are ignored
        add(1'b1, 1'b1, 16'h5555, 16'd0, 16'd480, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 16'h6666, 16'd0, 16'd480, 1'b0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 16'h7777, 16'd4, 16'd0, 1'b0, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'h7778, 16'd4, 16'd0, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].fs, tbl[i].pv, tbl[i].d, tbl[i].w, tbl[i].h);
            check($sformatf("vec[%0d]", i), tbl[i].ewr, tbl[i].ea, tbl[i].ed, tbl[i].edone,
                  tbl[i].eerr, tbl[i].epage);
        end

        // Reset asserted mid-frame after 3 pixels clears outputs at once
        step(1'b1, 1'b0, 16'h0000, 16'd4, 16'd2);
        step(1'b0, 1'b1, 16'h0071, 16'd4, 16'd2);
        step(1'b0, 1'b1, 16'h0072, 16'd4, 16'd2);
        step(1'b0, 1'b1, 16'h0073, 16'd4, 16'd2);
        check("pre_reset_write", 1'b1, 32'd2, 16'h0073, 1'b0, 1'b0, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset", 1'b0, 32'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        step(1'b0, 1'b1, 16'h0098, 16'd4, 16'd2);
        check("no_write_without_start", 1'b0, 32'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0099, 16'd4, 16'd2);
        check("restart_addr0", 1'b1, 32'd0, 16'h0099, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h009A, 16'd4, 16'd2);
        check("restart_addr1", 1'b1, 32'd1, 16'h009A, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic against the queue model
        do_reset();
        q.delete();
        m_addr = 32'd0;
        m_data = 16'h0000;
        m_page = 1'b0;
`ifdef FB_WR_SKIP_FIRST_FRAME_EN
        m_skip = 1'b1;
`else
        m_skip = 1'b0;
`endif
        for (int c = 0; c < 800; c++) begin
            logic        fs, pv, e_wr, e_done, e_err;
            logic [15:0] d, w, h;
            fs = ($urandom_range(0, 17) == 0);
            pv = ($urandom_range(0, 2) != 0);
            d  = 16'($urandom);
            w  = 16'($urandom_range(1, 4));
            h  = 16'($urandom_range(1, 3));
            e_err  = fs && (q.size() != 0);
            e_wr   = 1'b0;
            e_done = 1'b0;
            if (fs) begin
                q.delete();
                for (int a = 0; a < int'(w) * int'(h); a++) q.push_back(a);
            end
            if (pv && (q.size() != 0)) begin
                int a;
                a = q.pop_front();
                e_done = (q.size() == 0);
                if (!m_skip) begin
                    e_wr   = 1'b1;
                    m_addr = 32'(a);
                    m_data = d;
                end
                if (e_done) begin
                    if (m_skip) m_skip = 1'b0;
                    else m_page = 1'b1;
                end
            end
            step(fs, pv, d, w, h);
            check($sformatf("rand[%0d]", c), e_wr, m_addr, m_data, e_done, e_err, m_page);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_frame_buffer_write_only.md
# control_frame_buffer_write_only

Write-side controller for the video frame buffer. It accepts a captured pixel stream from the OV5640 capture path and generates synchronous write strobes, linear addresses and data for the frame-buffer RAM. It signals to the read-side controller, through `page_written_once_o`, when the first complete frame is in memory. It sits between the camera capture/format stage and the frame-buffer RAM write port. The read-side controller drains the same RAM toward HDMI.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of the frame-buffer address.
- `DATA_WIDTH`, 16: pixel width (RGB565).

Ports:
- `clk_i` in 1: single system clock; all logic on the rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `resolution_width_i` in 16: active pixels per line.
- `resolution_depth_i` in 16: active lines per frame.
- `frame_start_i` in 1: one-cycle pulse marking start of a frame, before its first pixel.
- `pixel_valid_i` in 1: `pixel_data_i` carries a valid pixel this cycle.
- `pixel_data_i` in DATA_WIDTH: pixel value.
- `wr_o` out 1: RAM write enable (registered).
- `addr_wr_o` out ADDR_WIDTH: RAM write address (registered).
- `data_wr_o` out DATA_WIDTH: RAM write data (registered).
- `frame_done_o` out 1: one-cycle pulse when the last pixel of a frame is written.
- `frame_err_o` out 1: one-cycle pulse when a frame is restarted before completion.
- `page_written_once_o` out 1: sticky flag, high once the first complete frame has been written.

## Operation
- `total_pixel_reg` = `resolution_width_i * resolution_depth_i - 1`.
  - Computed in ADDR_WIDTH bits.
  - Latched only on an accepted `frame_start_i`.
  - Resolution changes mid-frame have no effect.
- **S_WAIT_SYNC** (reset state):
  - Pixels are ignored: no `wr_o`, no pointer change.
  - `frame_start_i` with width≠0 and depth≠0: latch `total_pixel_reg`, clear pointer to 0, go to S_WRITE.
  - Zero width or depth: stay in S_WAIT_SYNC.
- **S_WRITE**:
  - Each `pixel_valid_i` writes `pixel_data_i` to the current pointer, then increments the pointer.
  - Writing pointer == `total_pixel_reg`: pulse `frame_done_o`, set `page_written_once_o`, go to S_WAIT_SYNC.
  - Pixels after the last one and before the next `frame_start_i` are dropped.
- **Short frame** (`frame_start_i` while in S_WRITE):
  - Pulse `frame_err_o`.
  - Re-latch resolution.
  - Restart the pointer at 0 and stay in S_WRITE.
  - `frame_done_o` does not pulse.
- **Simultaneous `frame_start_i` and `pixel_valid_i`**: frame start takes effect first. That pixel is written to address 0 and the pointer becomes 1.
- **Single-pixel frame** (total_pixel_reg = 0): start+pixel in the same cycle writes address 0. `frame_done_o` pulses and the FSM returns to S_WAIT_SYNC.
- **`page_written_once_o`**: clears only on reset. No other input clears it.
- **Backpressure**: none. The RAM port accepts one write per cycle; the capture path never exceeds one pixel per cycle.

## Timing
- Reset values:
  - `wr_o`=0, `addr_wr_o`=0, `data_wr_o`=0.
  - `frame_done_o`=0, `frame_err_o`=0, `page_written_once_o`=0.
  - Pointer=0, state=S_WAIT_SYNC.
- Latency: `pixel_valid_i` in cycle N → `wr_o`/`addr_wr_o`/`data_wr_o` valid in cycle N+1.
  - `wr_o` is high for exactly one cycle per accepted pixel.
  - `addr_wr_o`/`data_wr_o` hold their last value when `wr_o`=0.
- `frame_done_o` and `page_written_once_o` rise in the same cycle as `wr_o` for the last pixel.
- `frame_err_o` asserts in cycle N+1 for a `frame_start_i` seen in S_WRITE in cycle N.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately (asynchronously).
  - The next frame writes from address 0 only after a fresh `frame_start_i`.

## Configuration
- Macro `FB_WR_SKIP_FIRST_FRAME_EN`.
- Defined:
  - The first complete frame after reset is tracked through the FSM, but `wr_o` stays 0 for the whole frame; this discards the corrupt post-configuration OV5640 frame.
  - `frame_done_o` still pulses at the end of that frame.
  - `page_written_once_o` rises only at the end of the second frame, which is the first frame actually written.
  - A short first frame does not consume the skip.
- Undefined: every frame is written; `page_written_once_o` rises after the first complete frame.

## Test plan
- **Basic frame** (macro undefined): width=4, depth=2, `frame_start_i` then 8 back-to-back pixels 0x0001..0x0008.
  - Expect `wr_o` at addr 0..7 with data 0x0001..0x0008.
  - Expect `frame_done_o` and `page_written_once_o` rising in the cycle addr=7 is written.
- **Gapped pixels and overflow**: same frame with `pixel_valid_i` low every other cycle, followed by 3 extra pixels.
  - Expect addresses 0..7 only, each one cycle after its pixel.
  - Extra pixels produce no `wr_o`.
- **Short frame**: `frame_start_i` after 5 pixels, then 8 pixels.
  - Expect a `frame_err_o` pulse and writes restarting at addr 0.
  - Expect a single `frame_done_o` at the second frame's addr 7.
- **Coincident events**: `frame_start_i` and `pixel_valid_i` (data 0xABCD) in the same cycle from S_WAIT_SYNC.
  - Expect a write of 0xABCD at addr 0; the next pixel goes to addr 1.
- **Zero resolution and reset recovery**: width=0, depth=480, `frame_start_i` plus pixels → no writes.
  - Then width=4, depth=2, assert `reset_i` mid-frame after 3 pixels.
  - Expect all outputs 0 immediately; the next frame writes from addr 0.
- **Skip macro** (`FB_WR_SKIP_FIRST_FRAME_EN` defined): two 8-pixel frames.
  - Expect no `wr_o` during frame 1 and `frame_done_o` pulsing at the end of both frames.
  - Expect `page_written_once_o` rising only at the end of frame 2.
